uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 13 +
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the default tag base used for packet header beats.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } arb_state_e;

    localparam logic [7:0] HEADER_BASE_DEFAULT = 8'hF0;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the UART transmit arbiter.
// Valid/ready: a beat transfers on a rising clk edge where valid and ready are both high;
// valid must not wait on ready, and data stays stable while valid is high and ready is low.
interface uart_tx_arbiter_if #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
);
    import uart_tx_arbiter_pkg::*;

    logic [PORTS*DATA_WIDTH-1:0] s_axi_tdata;
    logic [PORTS-1:0]            s_axi_tvalid;
    logic [PORTS-1:0]            s_axi_tlast;
    logic [PORTS-1:0]            s_axi_tready;
    logic [DATA_WIDTH-1:0]       m_axi_tdata;
    logic                        m_axi_tvalid;
    logic                        m_axi_tready;
    logic [$clog2(PORTS)-1:0]    grant;
    logic                        busy;
    arb_state_e                  dbg_state;

    modport slave (
        input  s_axi_tdata, s_axi_tvalid, s_axi_tlast, m_axi_tready,
        output s_axi_tready, m_axi_tdata, m_axi_tvalid, grant, busy, dbg_state
    );

    modport master (
        output s_axi_tdata, s_axi_tvalid, s_axi_tlast, m_axi_tready,
        input  s_axi_tready, m_axi_tdata, m_axi_tvalid, grant, busy, dbg_state
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first requester strictly after last_grant,
// wrapping to port 0; last_grant itself is considered last.
module rr_arbiter #(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0]         req,
    input  logic [$clog2(PORTS)-1:0] last_grant,
    output logic [PORTS-1:0]         gnt_onehot,
    output logic [$clog2(PORTS)-1:0] gnt_idx
);
    localparam int IDX_W = $clog2(PORTS);

    logic found;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        // Ports above last_grant first, then the wrapped-around lower ports.
        for (int i = 0; i < PORTS; i++) begin
            if (!found && req[i] && (IDX_W'(i) > last_grant)) begin
                found         = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = IDX_W'(i);
            end
        end
        for (int i = 0; i < PORTS; i++) begin
            if (!found && req[i] && (IDX_W'(i) <= last_grant)) begin
                found         = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART transmitter through a
// single output register, optionally prefixing each packet with a port tag.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int         PORTS         = 4,
    parameter int         DATA_WIDTH    = 8,
    parameter int         HEADER_ENABLE = 1,
    parameter logic [7:0] HEADER_BASE   = HEADER_BASE_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(PORTS);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;

    logic [PORTS-1:0]      arb_onehot;
    logic [IDX_W-1:0]      arb_idx;
    logic [DATA_WIDTH-1:0] port_data [PORTS];
    logic [PORTS-1:0]      tready;
    logic                  out_free;
    logic                  accept;
    logic [DATA_WIDTH-1:0] tag;

    rr_arbiter #(.PORTS(PORTS)) u_rr (
        .req        (bus.s_axi_tvalid),
        .last_grant (last_grant_q),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx)
    );

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            port_data[i] = bus.s_axi_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Output register can take a new beat when empty or draining this cycle.
    assign out_free = !out_valid_q || bus.m_axi_tready;
    assign accept   = (state_q == ST_DATA) && bus.s_axi_tvalid[grant_q] && out_free;
    assign tag      = DATA_WIDTH'(32'(HEADER_BASE) + 32'(grant_q));

    always_comb begin
        tready = '0;
        if (state_q == ST_DATA) begin
            tready[grant_q] = out_free;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        if (bus.m_axi_tready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (|arb_onehot) begin
                    grant_d = arb_idx;
                    state_d = (HEADER_ENABLE != 0) ? ST_HEADER : ST_DATA;
                end
            end
            ST_HEADER: begin
                if (out_free) begin
                    out_data_d  = tag;
                    out_valid_d = 1'b1;
                    state_d     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    out_data_d  = port_data[grant_q];
                    out_valid_d = 1'b1;
                    if (bus.s_axi_tlast[grant_q]) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE) || out_valid_d;
    end

    // last_grant resets to the top port so port 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(PORTS - 1);
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.s_axi_tready = tready;
    assign bus.m_axi_tdata  = out_data_q;
    assign bus.m_axi_tvalid = out_valid_q;
    assign bus.grant        = grant_q;
    assign bus.busy         = busy_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-port packet lists, an order model built from
// the round-robin rule, and an expected-beat queue checked at the output.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int P    = 4;
    localparam int DW   = 8;
    localparam int IW   = 2;
    localparam int W    = DW + 1;
    localparam int MAXB = 64;

    logic clk;
    logic rst;
    logic use_n;
    logic [P*DW-1:0] drv_data;
    logic [P-1:0]    drv_valid;
    logic [P-1:0]    drv_last;
    logic            drv_mready;

    uart_tx_arbiter_if #(.PORTS(P), .DATA_WIDTH(DW)) if_h ();
    uart_tx_arbiter_if #(.PORTS(P), .DATA_WIDTH(DW)) if_n ();

    assign if_h.s_axi_tdata  = drv_data;
    assign if_h.s_axi_tlast  = drv_last;
    assign if_h.s_axi_tvalid = use_n ? '0 : drv_valid;
    assign if_h.m_axi_tready = use_n ? 1'b1 : drv_mready;
    assign if_n.s_axi_tdata  = drv_data;
    assign if_n.s_axi_tlast  = drv_last;
    assign if_n.s_axi_tvalid = use_n ? drv_valid : '0;
    assign if_n.m_axi_tready = use_n ? drv_mready : 1'b1;

    uart_tx_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .HEADER_ENABLE(1), .HEADER_BASE(8'hF0))
        dut_h (.clk(clk), .rst(rst), .bus(if_h.slave));
    uart_tx_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .HEADER_ENABLE(0), .HEADER_BASE(8'hF0))
        dut_n (.clk(clk), .rst(rst), .bus(if_n.slave));

    logic [P-1:0]  obs_tready;
    logic [DW-1:0] obs_mdata;
    logic          obs_mvalid;
    logic [IW-1:0] obs_grant;
    logic          obs_busy;
    arb_state_e    obs_state;

    assign obs_tready = use_n ? if_n.s_axi_tready : if_h.s_axi_tready;
    assign obs_mdata  = use_n ? if_n.m_axi_tdata  : if_h.m_axi_tdata;
    assign obs_mvalid = use_n ? if_n.m_axi_tvalid : if_h.m_axi_tvalid;
    assign obs_grant  = use_n ? if_n.grant        : if_h.grant;
    assign obs_busy   = use_n ? if_n.busy         : if_h.busy;
    assign obs_state  = use_n ? if_n.dbg_state    : if_h.dbg_state;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-port packet storage: data, last flag, idle cycles inserted before the beat
    logic [DW-1:0] bd [P][MAXB];
    logic          bl [P][MAXB];
    int            bg [P][MAXB];
    int            blen [P];
    int            bptr [P];
    int            gap_left [P];

    // Scoreboard: bit DW marks a tag beat, whose owner is in gnt_q
    logic [W-1:0]  exp_q[$];
    logic [IW-1:0] gnt_q[$];

    int n_vec, n_err, cyc, out_cnt, last_out_cyc;
    int ready_mode, stall_after, stall_left;
    int lg_h, lg_n;
    logic consec_chk, pend_chk, hold_chk;
    logic [DW-1:0] pend_data, hold_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ports();
        for (int p = 0; p < P; p++) begin
            blen[p] = 0;
            bptr[p] = 0;
            gap_left[p] = 0;
        end
    endtask

    task automatic add_pkt(input int p, input int n, input int gap_at, input int gap_len);
        for (int b = 0; b < n; b++) begin
            bd[p][blen[p]] = DW'($urandom);
            bl[p][blen[p]] = (b == n - 1);
            bg[p][blen[p]] = (b == gap_at && b > 0) ? gap_len : 0;
            blen[p]++;
        end
    endtask

    // Every pending port requests continuously, so packets leave in round-robin
    // order from lg+1 among ports that still hold packets.
    task automatic build_model(input bit hdr, input int lg_in, output int lg_out);
        int pos [P];
        int lg, win;
        bit last;
        lg = lg_in;
        for (int p = 0; p < P; p++) pos[p] = bptr[p];
        forever begin
            win = -1;
            for (int k = 1; k <= P; k++) begin
                if (win < 0 && pos[(lg + k) % P] < blen[(lg + k) % P]) win = (lg + k) % P;
            end
            if (win < 0) break;
            if (hdr) begin
                exp_q.push_back({1'b1, DW'(240 + win)});
                gnt_q.push_back(IW'(win));
            end
            do begin
                exp_q.push_back({1'b0, bd[win][pos[win]]});
                last = bl[win][pos[win]];
                pos[win]++;
            end while (!last);
            lg = win;
        end
        lg_out = lg;
    endtask

    task automatic drive();
        drv_valid = '0;
        drv_last  = '0;
        drv_data  = '0;
        for (int p = 0; p < P; p++) begin
            if (gap_left[p] > 0) begin
                gap_left[p]--;
            end else if (bptr[p] < blen[p]) begin
                drv_valid[p] = 1'b1;
                drv_last[p]  = bl[p][bptr[p]];
                drv_data[p*DW +: DW] = bd[p][bptr[p]];
            end
        end
        if (stall_left > 0 && out_cnt >= stall_after) begin
            drv_mready = 1'b0;
            stall_left--;
        end else if (ready_mode == 1) begin
            drv_mready = ($urandom_range(0, 3) != 0);
        end else begin
            drv_mready = 1'b1;
        end
    endtask

    // One clock: drive at negedge, check just after, advance after the posedge.
    task automatic step();
        logic [P-1:0] fire, gmask, bad;
        logic [W-1:0] e;
        drive();
        #1;
        if (pend_chk) begin
            chk("accept_valid", 32'(obs_mvalid), 1);
            chk("accept_data", 32'(obs_mdata), 32'(pend_data));
        end
        if (hold_chk) begin
            chk("hold_valid", 32'(obs_mvalid), 1);
            chk("hold_data", 32'(obs_mdata), 32'(hold_data));
        end
        gmask = '0;
        gmask[obs_grant] = 1'b1;
        bad = obs_tready & ~gmask;
        if (obs_mvalid && !drv_mready) bad = bad | obs_tready;
        chk("tready_rule", 32'(bad), 0);
        if (obs_mvalid) chk("busy_high", 32'(obs_busy), 1);
        fire = drv_valid & obs_tready;
        if (obs_mvalid && drv_mready) begin
            chk("beat_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_beat", 32'(obs_mdata), 32'(e[DW-1:0]));
                if (e[DW] && gnt_q.size() > 0) chk("grant", 32'(obs_grant), 32'(gnt_q.pop_front()));
            end
            if (consec_chk && out_cnt > 0) chk("consecutive", cyc, last_out_cyc + 1);
            last_out_cyc = cyc;
            out_cnt++;
        end
        pend_chk = |fire;
        for (int p = 0; p < P; p++) if (fire[p]) pend_data = bd[p][bptr[p]];
        hold_chk  = obs_mvalid && !drv_mready;
        hold_data = obs_mdata;
        @(posedge clk);
        cyc++;
        for (int p = 0; p < P; p++) begin
            if (fire[p]) begin
                bptr[p]++;
                if (bptr[p] < blen[p]) gap_left[p] = bg[p][bptr[p]];
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int budget);
        int n;
        bit done;
        n = 0;
        out_cnt = 0;
        forever begin
            done = (exp_q.size() == 0);
            for (int p = 0; p < P; p++) if (bptr[p] < blen[p]) done = 1'b0;
            if (done || n >= budget) break;
            step();
            n++;
        end
        chk("run_complete", 32'(done), 1);
        exp_q.delete();
        gnt_q.delete();
        step();
        step();
        chk("idle_busy", 32'(obs_busy), 0);
        chk("idle_state", 32'(obs_state), 32'(ST_IDLE));
    endtask

    task automatic check_reset_values();
        chk("rst_mvalid", 32'(obs_mvalid), 0);
        chk("rst_mdata", 32'(obs_mdata), 0);
        chk("rst_tready", 32'(obs_tready), 0);
        chk("rst_grant", 32'(obs_grant), 0);
        chk("rst_busy", 32'(obs_busy), 0);
        chk("rst_state", 32'(obs_state), 32'(ST_IDLE));
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; out_cnt = 0; last_out_cyc = 0;
        ready_mode = 0; stall_after = 0; stall_left = 0;
        consec_chk = 1'b0; pend_chk = 1'b0; hold_chk = 1'b0;
        pend_data = '0; hold_data = '0;
        use_n = 1'b0;
        drv_data = '0; drv_valid = '0; drv_last = '0; drv_mready = 1'b1;
        clear_ports();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        lg_h = P - 1;
        lg_n = P - 1;
        @(negedge clk);

        // All four ports send a 2-beat packet at once: F0,p0,p0,F1,...,F3,p3,p3
        clear_ports();
        for (int p = 0; p < P; p++) add_pkt(p, 2, 0, 0);
        build_model(1'b1, lg_h, lg_h);
        run(200);

        // Port 1 alone, so port 2 is next in line for the alternation test
        clear_ports();
        add_pkt(1, 1, 0, 0);
        build_model(1'b1, lg_h, lg_h);
        run(50);

        // Port 2: three single-beat packets; port 1 keeps requesting -> 2,1,2,1,2
        clear_ports();
        for (int k = 0; k < 3; k++) add_pkt(2, 1, 0, 0);
        for (int k = 0; k < 2; k++) add_pkt(1, 2, 0, 0);
        build_model(1'b1, lg_h, lg_h);
        run(200);

        // Ten-cycle transmitter stall in the middle of a packet
        clear_ports();
        add_pkt(0, 6, 0, 0);
        stall_after = 3;
        stall_left  = 10;
        build_model(1'b1, lg_h, lg_h);
        run(200);

        // Random packets, random backpressure, random mid-packet valid gaps
        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            clear_ports();
            for (int p = 0; p < P; p++) begin
                int npk;
                npk = $urandom_range(0, 2);
                for (int k = 0; k < npk; k++)
                    add_pkt(p, $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(0, 3));
            end
            build_model(1'b1, lg_h, lg_h);
            run(2000);
        end
        ready_mode = 0;

        // Reset while port 1 is mid-packet
        clear_ports();
        add_pkt(1, 4, 0, 0);
        build_model(1'b1, lg_h, lg_h);
        for (int n = 0; n < 50 && bptr[1] < 2; n++) step();
        chk("reached_data", 32'(bptr[1] >= 2), 1);
        rst = 1'b1;
        clear_ports();
        drv_valid = '0;
        drv_last  = '0;
        #1;
        check_reset_values();
        exp_q.delete();
        gnt_q.delete();
        pend_chk = 1'b0;
        hold_chk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        lg_h = P - 1;
        lg_n = P - 1;
        @(negedge clk);
        clear_ports();
        add_pkt(0, 3, 0, 0);
        build_model(1'b1, lg_h, lg_h);
        run(100);

        // Port 1 owns and drops valid for 5 cycles while port 0 waits
        clear_ports();
        add_pkt(1, 4, 2, 5);
        add_pkt(0, 2, 0, 0);
        build_model(1'b1, lg_h, lg_h);
        run(200);

        // No-header instance: port 3 streams 8 beats back to back
        use_n = 1'b1;
        clear_ports();
        add_pkt(3, 8, 0, 0);
        consec_chk = 1'b1;
        build_model(1'b0, lg_n, lg_n);
        run(100);
        chk("stream_beats", out_cnt, 8);
        consec_chk = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
